// File: rtl/npu_matvec_accel.sv
`default_nettype none
// ============================================================================
//  Module      : npu_matvec_accel
//  Description : AXI4-Lite NPU tile computing out = W*x on an 8x8 Q8.8
//                matrix with saturation and optional ReLU.
//  Revision    : 1.0 - initial release
// ============================================================================
module npu_matvec_accel #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int MATRIX_SIZE    = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        interrupt
);

    // Word addresses (byte address [9:2]) of the control registers
    localparam logic [7:0] c_W_CTRL       = 8'h00;
    localparam logic [7:0] c_W_STATUS     = 8'h01;
    localparam logic [7:0] c_W_CONFIG     = 8'h02;
    localparam logic [7:0] c_W_INT_STATUS = 8'h03;
    localparam logic [7:0] c_W_INT_EN     = 8'h04;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t                   state_q;
    logic                     awready_q, bvalid_q, arready_q, rvalid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                     busy_q, done_q, irq_q, int_en_q, soft_rst_q, relu_q;
    logic [7:0]               cfg_size_q;
    logic [3:0]               row_q, col_q;
    logic signed [39:0]       acc_q;
    logic [DATA_WIDTH-1:0]    weight_q [MATRIX_SIZE*MATRIX_SIZE];
    logic [DATA_WIDTH-1:0]    vec_q    [MATRIX_SIZE];
    logic [DATA_WIDTH-1:0]    res_q    [MATRIX_SIZE];

    logic                     w_wr_en, w_rd_en, w_start;
    logic [7:0]               w_wword, w_rword;
    logic [3:0]               w_n, w_last;
    logic signed [31:0]       w_prod;
    logic signed [39:0]       w_shift;
    logic [DATA_WIDTH-1:0]    w_res;
    logic [AXI_DATA_WIDTH-1:0] w_rdata;
    logic                     w_unused;

    assign w_wr_en = awready_q && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_en = arready_q && s_axi_arvalid;
    assign w_wword = s_axi_awaddr[9:2];
    assign w_rword = s_axi_araddr[9:2];
    // Writing start together with soft_rst=1 does not launch a job
    assign w_start = w_wr_en && (w_wword == c_W_CTRL) && s_axi_wstrb[0]
                     && s_axi_wdata[1] && !s_axi_wdata[0];

    // Size 0 or anything above 8 selects the full matrix
    assign w_n    = ((cfg_size_q == 8'd0) || (cfg_size_q > 8'd8)) ? 4'd8 : cfg_size_q[3:0];
    assign w_last = w_n - 4'd1;

    assign w_prod  = $signed(weight_q[{row_q[2:0], col_q[2:0]}]) * $signed(vec_q[col_q[2:0]]);
    assign w_shift = acc_q >>> 8;

    // Requantise the accumulator back to Q8.8 with saturation and ReLU
    always_comb begin
        if (w_shift > 40'sd32767)
            w_res = 16'h7FFF;
        else if (w_shift < -40'sd32768)
            w_res = 16'h8000;
        else
            w_res = w_shift[15:0];
        if (relu_q && w_res[15])
            w_res = 16'h0000;
    end

    // Read data mux; data words are zero-extended, holes read as zero
    always_comb begin
        w_rdata = '0;
        if (w_rword[7:6] == 2'b01)
            w_rdata[DATA_WIDTH-1:0] = weight_q[w_rword[5:0]];
        else if (w_rword[7:3] == 5'b10000)
            w_rdata[DATA_WIDTH-1:0] = vec_q[w_rword[2:0]];
        else if (w_rword[7:3] == 5'b11000)
            w_rdata[DATA_WIDTH-1:0] = res_q[w_rword[2:0]];
        else begin
            case (w_rword)
                c_W_CTRL:       w_rdata[0]   = soft_rst_q;
                c_W_STATUS:     w_rdata[1:0] = {done_q, busy_q};
                c_W_CONFIG:     w_rdata[8:0] = {relu_q, cfg_size_q};
                c_W_INT_STATUS: w_rdata[0]   = irq_q;
                c_W_INT_EN:     w_rdata[0]   = int_en_q;
                default:        w_rdata      = '0;
            endcase
        end
    end

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [AXI_DATA_WIDTH-1:0] d,
                                            input logic [AXI_DATA_WIDTH/8-1:0] s);
        merge16 = old_v;
        if (s[0]) merge16[7:0]  = d[7:0];
        if (s[1]) merge16[15:8] = d[15:8];
    endfunction

    // AXI handshake: one-cycle readies, responses held until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
            if (w_wr_en)
                bvalid_q <= 1'b1;
            else if (s_axi_bready)
                bvalid_q <= 1'b0;
            arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
            if (w_rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= w_rdata;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Weight and input-vector storage, writable only while no job runs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < MATRIX_SIZE*MATRIX_SIZE; k++) weight_q[k] <= '0;
            for (int k = 0; k < MATRIX_SIZE; k++) vec_q[k] <= '0;
        end else if (w_wr_en && !busy_q) begin
            if (w_wword[7:6] == 2'b01)
                weight_q[w_wword[5:0]] <= merge16(weight_q[w_wword[5:0]], s_axi_wdata, s_axi_wstrb);
            else if (w_wword[7:3] == 5'b10000)
                vec_q[w_wword[2:0]] <= merge16(vec_q[w_wword[2:0]], s_axi_wdata, s_axi_wstrb);
        end
    end

    // Control registers, MAC sequencer and result store
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            int_en_q   <= 1'b1;
            soft_rst_q <= 1'b0;
            relu_q     <= 1'b0;
            cfg_size_q <= 8'd8;
            row_q      <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            for (int k = 0; k < MATRIX_SIZE; k++) res_q[k] <= '0;
        end else begin
            if (w_wr_en) begin
                if ((w_wword == c_W_CTRL) && s_axi_wstrb[0])
                    soft_rst_q <= s_axi_wdata[0];
                if ((w_wword == c_W_INT_EN) && s_axi_wstrb[0])
                    int_en_q <= s_axi_wdata[0];
                if ((w_wword == c_W_CONFIG) && !busy_q) begin
                    if (s_axi_wstrb[0]) cfg_size_q <= s_axi_wdata[7:0];
                    if (s_axi_wstrb[1]) relu_q     <= s_axi_wdata[8];
                end
                if ((w_wword == c_W_INT_STATUS) && s_axi_wstrb[0] && s_axi_wdata[0])
                    irq_q <= 1'b0;
            end
            if (soft_rst_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                irq_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_start) begin
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            row_q   <= '0;
                            col_q   <= '0;
                            acc_q   <= '0;
                            // Rows beyond N stay zero because they are never stored
                            for (int k = 0; k < MATRIX_SIZE; k++) res_q[k] <= '0;
                            state_q <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        acc_q <= acc_q + 40'(w_prod);
                        if (col_q == w_last)
                            state_q <= S_STORE;
                        else
                            col_q <= col_q + 4'd1;
                    end
                    S_STORE: begin
                        res_q[row_q[2:0]] <= w_res;
                        acc_q <= '0;
                        col_q <= '0;
                        if (row_q == w_last) begin
                            state_q <= S_DONE;
                        end else begin
                            row_q   <= row_q + 4'd1;
                            state_q <= S_MAC;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;   // overrides a same-cycle W1C
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign interrupt     = irq_q && int_en_q;

    assign w_unused = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:10], s_axi_awaddr[1:0],
                        s_axi_araddr[AXI_ADDR_WIDTH-1:10], s_axi_araddr[1:0],
                        s_axi_awprot, s_axi_arprot,
                        s_axi_wdata[AXI_DATA_WIDTH-1:16], s_axi_wstrb[AXI_DATA_WIDTH/8-1:2]};

endmodule
`default_nettype wire

// File: tb/tb_npu_matvec_accel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_matvec_accel
//  Description : Self-checking bench for npu_matvec_accel (job table plus
//                hand-written busy / soft-reset sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_matvec_accel;

    localparam logic [31:0] A_CTRL   = 32'h000;
    localparam logic [31:0] A_STATUS = 32'h004;
    localparam logic [31:0] A_CONFIG = 32'h008;
    localparam logic [31:0] A_INTST  = 32'h00C;
    localparam logic [31:0] A_INTEN  = 32'h010;
    localparam logic [31:0] A_W      = 32'h100;
    localparam logic [31:0] A_X      = 32'h200;
    localparam logic [31:0] A_OUT    = 32'h300;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic        interrupt;

    npu_matvec_accel dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .interrupt(interrupt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, bv_cyc = 0, irq_cyc = 0;
    logic bv_prev = 1'b0, irq_prev = 1'b0;
    logic [15:0] tw [64];
    logic [15:0] tx [8];
    logic [15:0] exp_q [$];

    typedef struct packed {
        logic [2:0]  mode;   // 0 identity, 1 W00=-1, 2 all 0x7F00, 3 random, 4 negative sat
        logic [7:0]  size;
        logic        relu;
        logic        chk0;
        logic [15:0] exp0;
        logic [7:0]  lat;
    } job_t;
    job_t jobs [9];

    // Timestamps of bvalid / interrupt rising edges, sampled after each edge
    always @(posedge aclk) begin
        #1;
        cyc = cyc + 1;
        if (s_axi_bvalid && !bv_prev) bv_cyc = cyc;
        if (interrupt && !irq_prev) irq_cyc = cyc;
        bv_prev  = s_axi_bvalid;
        irq_prev = interrupt;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge aclk);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_awready && n < 50);
        if (!s_axi_awready) timeout("awready");
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_bvalid && n < 50);
        if (!s_axi_bvalid) timeout("bvalid");
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        @(negedge aclk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 50);
        if (!s_axi_arready) timeout("arready");
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_rvalid && n < 50);
        if (!s_axi_rvalid) timeout("rvalid");
        data = s_axi_rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        axi_read(addr, rd);
        check(name, rd, exp);
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n = 0;
        while (!interrupt && n < budget) begin @(negedge aclk); n++; end
        if (!interrupt) timeout(name);
    endtask

    task automatic fill(input logic [2:0] mode);
        for (int k = 0; k < 64; k++) begin
            case (mode)
                3'd0: tw[k] = (k / 8 == k % 8) ? 16'h0100 : 16'h0000;
                3'd1: tw[k] = (k == 0) ? 16'hFF00 : 16'h0000;
                3'd2: tw[k] = 16'h7F00;
                3'd3: tw[k] = 16'($urandom_range(0, 1024)) - 16'd512;
                default: tw[k] = 16'h8000;
            endcase
        end
        for (int j = 0; j < 8; j++) begin
            case (mode)
                3'd0, 3'd1: tx[j] = 16'h0100;
                3'd3: tx[j] = 16'($urandom_range(0, 1024)) - 16'd512;
                default: tx[j] = 16'h7F00;
            endcase
        end
    endtask

    task automatic load_arrays();
        for (int k = 0; k < 64; k++) axi_write(A_W + 32'(4 * k), {16'h0, tw[k]}, 4'hF);
        for (int j = 0; j < 8; j++) axi_write(A_X + 32'(4 * j), {16'h0, tx[j]}, 4'hF);
    endtask

    // Reference model: Q8.8 dot products, arithmetic shift, saturate, ReLU
    task automatic push_expected(input logic [7:0] size, input logic relu);
        int n;
        longint acc, v;
        logic [15:0] r;
        n = (size == 8'd0 || size > 8'd8) ? 8 : int'(size);
        for (int i = 0; i < 8; i++) begin
            acc = 0;
            if (i < n)
                for (int j = 0; j < n; j++)
                    acc += longint'($signed(tw[i*8+j])) * longint'($signed(tx[j]));
            v = acc >>> 8;
            if (v > 32767) r = 16'h7FFF;
            else if (v < -32768) r = 16'h8000;
            else r = v[15:0];
            if (relu && r[15]) r = 16'h0000;
            exp_q.push_back(r);
        end
    endtask

    task automatic check_outputs(input int tag, input logic chk0, input logic [15:0] exp0);
        logic [31:0] rd;
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            axi_read(A_OUT + 32'(4 * i), rd);
            if (exp_q.size() == 0) begin
                timeout("scoreboard_empty");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("job%0d_out%0d", tag, i), rd, {16'h0, e});
            end
            if (i == 0 && chk0) check($sformatf("job%0d_out0_const", tag), rd, {16'h0, exp0});
        end
    endtask

    task automatic run_job(input int tag, input job_t j);
        int start_cyc;
        fill(j.mode);
        axi_write(A_CONFIG, {23'h0, j.relu, j.size}, 4'hF);
        load_arrays();
        push_expected(j.size, j.relu);
        axi_write(A_CTRL, 32'h2, 4'hF);
        start_cyc = bv_cyc;
        read_check($sformatf("job%0d_status_busy", tag), A_STATUS, 32'h1);
        wait_irq($sformatf("job%0d_irq_wait", tag), 300);
        check($sformatf("job%0d_irq", tag), {31'h0, interrupt}, 32'h1);
        check($sformatf("job%0d_latency", tag), 32'(irq_cyc - start_cyc), {24'h0, j.lat});
        read_check($sformatf("job%0d_status_done", tag), A_STATUS, 32'h2);
        check_outputs(tag, j.chk0, j.exp0);
        axi_write(A_INTST, 32'h1, 4'hF);
        read_check($sformatf("job%0d_intst_clr", tag), A_INTST, 32'h0);
        check($sformatf("job%0d_irq_clr", tag), {31'h0, interrupt}, 32'h0);
        read_check($sformatf("job%0d_done_sticky", tag), A_STATUS, 32'h2);
    endtask

    initial begin
        //            mode  size   relu  chk0  exp0      lat
        jobs[0] = {3'd0, 8'd8,  1'b1, 1'b1, 16'h0100, 8'd73};
        jobs[1] = {3'd1, 8'd8,  1'b0, 1'b1, 16'hFF00, 8'd73};
        jobs[2] = {3'd1, 8'd8,  1'b1, 1'b1, 16'h0000, 8'd73};
        jobs[3] = {3'd2, 8'd8,  1'b0, 1'b1, 16'h7FFF, 8'd73};
        jobs[4] = {3'd2, 8'd4,  1'b0, 1'b1, 16'h7FFF, 8'd21};
        jobs[5] = {3'd4, 8'd8,  1'b0, 1'b1, 16'h8000, 8'd73};
        jobs[6] = {3'd0, 8'd12, 1'b0, 1'b1, 16'h0100, 8'd73};
        jobs[7] = {3'd3, 8'd0,  1'b0, 1'b0, 16'h0000, 8'd73};
        jobs[8] = {3'd3, 8'd3,  1'b1, 1'b0, 16'h0000, 8'd13};

        repeat (4) @(negedge aclk);
        check("rst_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
        check("rst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_irq", {31'h0, interrupt}, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);
        read_check("rst_intst", A_INTST, 32'h0);
        read_check("rst_config", A_CONFIG, 32'h8);
        read_check("rst_inten", A_INTEN, 32'h1);
        read_check("rst_out3", A_OUT + 32'hC, 32'h0);

        // Byte strobes, zero extension and unmapped space
        axi_write(A_W, 32'h0000_1234, 4'hF);
        axi_write(A_W, 32'h0000_ABCD, 4'h1);
        read_check("wstrb_low", A_W, 32'h0000_12CD);
        axi_write(A_W, 32'h0000_5600, 4'h2);
        read_check("wstrb_high", A_W, 32'h0000_56CD);
        axi_write(A_X + 32'h1C, 32'hFFFF_5A5A, 4'hF);
        read_check("x_zext", A_X + 32'h1C, 32'h0000_5A5A);
        axi_write(32'h0F0, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped", 32'h3FC, 32'h0);

        for (int k = 0; k < 9; k++) run_job(k, jobs[k]);

        // Busy lockout and soft reset in the middle of a job
        fill(3'd3);
        axi_write(A_CONFIG, 32'h0000_0008, 4'hF);
        load_arrays();
        axi_write(A_CTRL, 32'h2, 4'hF);
        axi_write(A_CONFIG, 32'h0000_0103, 4'hF);
        axi_write(A_W, 32'h0000_7F00, 4'hF);
        read_check("busy_config_locked", A_CONFIG, 32'h8);
        read_check("busy_status", A_STATUS, 32'h1);
        axi_write(A_CTRL, 32'h1, 4'hF);
        read_check("srst_status", A_STATUS, 32'h0);
        read_check("srst_intst", A_INTST, 32'h0);
        read_check("srst_ctrl", A_CTRL, 32'h1);
        repeat (100) @(negedge aclk);
        check("srst_no_irq", {31'h0, interrupt}, 32'h0);
        read_check("srst_status_idle", A_STATUS, 32'h0);
        axi_write(A_CTRL, 32'h0, 4'hF);
        push_expected(8'd8, 1'b0);
        axi_write(A_CTRL, 32'h2, 4'hF);
        wait_irq("restart_irq_wait", 300);
        read_check("restart_status", A_STATUS, 32'h2);
        check_outputs(99, 1'b0, 16'h0);

        // INT_EN masks the line but not the status bit
        axi_write(A_INTST, 32'h1, 4'hF);
        axi_write(A_INTEN, 32'h0, 4'hF);
        axi_write(A_CTRL, 32'h2, 4'hF);
        repeat (120) @(negedge aclk);
        check("masked_irq", {31'h0, interrupt}, 32'h0);
        read_check("masked_intst", A_INTST, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
